// File: rtl/bomb_projectile.sv
// bomb_projectile: the responder side of the player launch interface.
// It flies a ballistic bomb one step per frame tick and detects terrain impact.
// On impact it writes back a cratered terrain word and then holds a growing explosion window.
module bomb_projectile #(
  parameter int unsigned GRAV_DIV     = 6,
  parameter int unsigned V_MAX        = 10,
  parameter int unsigned X_MAX        = 634,
  parameter int unsigned Y_MAX        = 474,
  parameter int unsigned FLIGHT_S     = 2,
  parameter int unsigned BLAST_FRAMES = 16,
  parameter int unsigned CRATER_DEPTH = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         frame_clk,
  input  logic         launch,
  input  logic [9:0]   launchX,
  input  logic [9:0]   launchY,
  input  logic [3:0]   angle,
  input  logic [2:0]   power,
  input  logic [511:0] terrain_data,
  output logic [9:0]   X,
  output logic [9:0]   Y,
  output logic [9:0]   S,
  output logic         exploded,
  output logic         busy,
  output logic [511:0] terrain_out,
  output logic         terrain_we
);

  // Only columns 0..39 are on screen (640 px / 16 px per column).
  localparam logic [5:0]        LastCol = 6'd39;
  localparam logic [11:0]       GroundY = 12'd479;
  localparam logic signed [9:0] VMaxS   = 10'(V_MAX);
  localparam logic signed [9:0] VMinS   = -VMaxS;
  localparam logic [7:0]        DepthC  = 8'(CRATER_DEPTH);
  localparam logic [7:0]        DepthN  = 8'(CRATER_DEPTH / 2);

  typedef enum logic [1:0] {StIdle, StFlight, StCrater, StBlast} state_e;

  state_e r_state, w_state_next;

  logic              r_frame_q, r_launch_q;
  logic [9:0]        r_x, r_y;
  logic signed [9:0] r_vx, r_vy;
  logic [7:0]        r_grav_cnt, r_blast_cnt;
  logic [511:0]      r_terrain;
  logic              r_we;

  logic              w_tick, w_launch_edge;
  logic signed [9:0] w_bx, w_by, w_pw, w_vx0, w_vy0;
  logic [3:0]        w_pw1;
  logic [5:0]        w_col;
  logic [8:0]        w_base;
  logic [7:0]        w_h;
  logic              w_hit, w_dud, w_grav_wrap;
  logic signed [10:0] w_nx, w_ny;
  logic [9:0]        w_y_move;
  logic signed [9:0] w_vy_inc, w_vy_clamp;
  logic [511:0]      w_crater;

  assign w_tick        = frame_clk & ~r_frame_q;
  assign w_launch_edge = launch & ~r_launch_q;

  // Launch direction table; angles 10..15 fold onto 9.
  always_comb begin
    w_bx = 10'sd4;
    w_by = -10'sd1;
    case (angle)
      4'd0:    begin w_bx = -10'sd4; w_by = -10'sd1; end
      4'd1:    begin w_bx = -10'sd3; w_by = -10'sd2; end
      4'd2:    begin w_bx = -10'sd3; w_by = -10'sd3; end
      4'd3:    begin w_bx = -10'sd2; w_by = -10'sd4; end
      4'd4:    begin w_bx = -10'sd1; w_by = -10'sd4; end
      4'd5:    begin w_bx = 10'sd1;  w_by = -10'sd4; end
      4'd6:    begin w_bx = 10'sd2;  w_by = -10'sd4; end
      4'd7:    begin w_bx = 10'sd3;  w_by = -10'sd3; end
      4'd8:    begin w_bx = 10'sd3;  w_by = -10'sd2; end
      default: begin w_bx = 10'sd4;  w_by = -10'sd1; end
    endcase
  end

  assign w_pw1 = {1'b0, power} + 4'd1;
  assign w_pw  = $signed({6'd0, w_pw1});
  assign w_vx0 = (w_bx * w_pw) >>> 1;
  assign w_vy0 = (w_by * w_pw) >>> 1;

  // Impact test uses the column under the bomb centre.
  assign w_col  = r_x[9:4];
  assign w_base = {w_col, 3'b000};
  assign w_h    = terrain_data[w_base +: 8];
  assign w_hit  = ({2'b00, r_y} + 12'(FLIGHT_S) + {4'b0000, w_h}) >= GroundY;

  assign w_nx     = $signed({1'b0, r_x}) + $signed({r_vx[9], r_vx});
  assign w_ny     = $signed({1'b0, r_y}) + $signed({r_vy[9], r_vy});
  assign w_dud    = w_nx[10] | (w_nx[9:0] > 10'(X_MAX)) | (~w_ny[10] & (w_ny[9:0] > 10'(Y_MAX)));
  assign w_y_move = w_ny[10] ? 10'd0 : w_ny[9:0];

  assign w_grav_wrap = (r_grav_cnt == 8'(GRAV_DIV - 1));
  assign w_vy_inc    = w_grav_wrap ? (r_vy + 10'sd1) : r_vy;

  // Vertical speed clamp, applied after the gravity step.
  always_comb begin
    w_vy_clamp = w_vy_inc;
    if (w_vy_inc > VMaxS)      w_vy_clamp = VMaxS;
    else if (w_vy_inc < VMinS) w_vy_clamp = VMinS;
  end

  function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? (a - b) : 8'd0;
  endfunction

  // Crater word: hit column loses full depth, on-screen neighbours lose half.
  always_comb begin
    w_crater = terrain_data;
    w_crater[w_base +: 8] = sat_sub(w_h, DepthC);
    if (w_col != 6'd0) begin
      w_crater[(w_base - 9'd8) +: 8] = sat_sub(terrain_data[(w_base - 9'd8) +: 8], DepthN);
    end
    if (w_col < LastCol) begin
      w_crater[(w_base + 9'd8) +: 8] = sat_sub(terrain_data[(w_base + 9'd8) +: 8], DepthN);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  // Next-state logic; impact has priority over leaving the screen.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:   if (w_launch_edge) w_state_next = StFlight;
      StFlight: begin
        if (w_tick) begin
          if (w_hit)      w_state_next = StCrater;
          else if (w_dud) w_state_next = StIdle;
        end
      end
      StCrater: w_state_next = StBlast;
      StBlast:  if (w_tick && (r_blast_cnt == 8'(BLAST_FRAMES - 1))) w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    S        = 10'd0;
    exploded = 1'b0;
    busy     = 1'b1;
    case (r_state)
      StIdle:   busy = 1'b0;
      StFlight: S = 10'(FLIGHT_S);
      StCrater: S = 10'(FLIGHT_S);
      StBlast:  begin
        S        = 10'd2 + {2'b00, r_blast_cnt};
        exploded = 1'b1;
      end
      default:  busy = 1'b0;
    endcase
  end

  // Datapath: edge detectors, kinematics, counters and terrain write-back.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame_q   <= 1'b0;
      r_launch_q  <= 1'b0;
      r_x         <= 10'd0;
      r_y         <= 10'd0;
      r_vx        <= 10'sd0;
      r_vy        <= 10'sd0;
      r_grav_cnt  <= 8'd0;
      r_blast_cnt <= 8'd0;
      r_terrain   <= '0;
      r_we        <= 1'b0;
    end else begin
      r_frame_q  <= frame_clk;
      r_launch_q <= launch;
      r_terrain  <= (r_state == StCrater) ? w_crater : terrain_data;
      r_we       <= (r_state == StCrater);
      case (r_state)
        StIdle: begin
          if (w_launch_edge) begin
            r_x        <= launchX;
            r_y        <= launchY;
            r_vx       <= w_vx0;
            r_vy       <= w_vy0;
            r_grav_cnt <= 8'd0;
          end
        end
        StFlight: begin
          if (w_tick && !w_hit && !w_dud) begin
            r_x        <= w_nx[9:0];
            r_y        <= w_y_move;
            r_vy       <= w_vy_clamp;
            r_grav_cnt <= w_grav_wrap ? 8'd0 : (r_grav_cnt + 8'd1);
          end
        end
        StCrater: r_blast_cnt <= 8'd0;
        StBlast:  if (w_tick) r_blast_cnt <= r_blast_cnt + 8'd1;
        default:  ;
      endcase
    end
  end

  assign X           = r_x;
  assign Y           = r_y;
  assign terrain_out = r_terrain;
  assign terrain_we  = r_we;

endmodule

// File: tb/tb_bomb_projectile.sv
// Self-checking bench for bomb_projectile: directed scenarios plus randomized traffic,
// all compared every cycle against a behavioural model of the bomb's flight rules.
module tb_bomb_projectile;

  logic         clk = 1'b0;
  logic         reset;
  logic         frame_clk;
  logic         launch;
  logic [9:0]   launchX, launchY;
  logic [3:0]   angle;
  logic [2:0]   power;
  logic [511:0] terrain_data;
  logic [9:0]   X, Y, S;
  logic         exploded, busy;
  logic [511:0] terrain_out;
  logic         terrain_we;

  int checks = 0;
  int errors = 0;

  bomb_projectile dut (
    .clk          (clk),
    .reset        (reset),
    .frame_clk    (frame_clk),
    .launch       (launch),
    .launchX      (launchX),
    .launchY      (launchY),
    .angle        (angle),
    .power        (power),
    .terrain_data (terrain_data),
    .X            (X),
    .Y            (Y),
    .S            (S),
    .exploded     (exploded),
    .busy         (busy),
    .terrain_out  (terrain_out),
    .terrain_we   (terrain_we)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int col_h(input logic [511:0] t, input int c);
    return int'(t[8*c +: 8]);
  endfunction

  // Crater rule over a plain array of column heights.
  function automatic logic [511:0] crater_of(input logic [511:0] t, input int c);
    int h[64];
    logic [511:0] r;
    for (int i = 0; i < 64; i++) h[i] = col_h(t, i);
    h[c] = (h[c] > 12) ? h[c] - 12 : 0;
    if (c > 0)  h[c-1] = (h[c-1] > 6) ? h[c-1] - 6 : 0;
    if (c < 39) h[c+1] = (h[c+1] > 6) ? h[c+1] - 6 : 0;
    for (int i = 0; i < 64; i++) r[8*i +: 8] = 8'(h[i]);
    return r;
  endfunction

  // Behavioural model: mode 0 idle, 1 flying, 2 cratering, 3 exploding.
  int           m_mode = 0, m_x = 0, m_y = 0, m_vx = 0, m_vy = 0, m_g = 0, m_b = 0;
  bit           m_fq = 0, m_lq = 0, m_we = 0;
  logic [511:0] m_tout = '0;
  int           bx_tab[10] = '{-4, -3, -3, -2, -1, 1, 2, 3, 3, 4};
  int           by_tab[10] = '{-1, -2, -3, -4, -4, -4, -4, -3, -2, -1};

  always @(posedge clk) begin
    bit tick, ledge;
    int a, nx, ny;
    tick  = frame_clk && !m_fq;
    ledge = launch && !m_lq;
    if (reset) begin
      m_mode = 0; m_x = 0; m_y = 0; m_vx = 0; m_vy = 0; m_g = 0; m_b = 0;
      m_fq = 0; m_lq = 0; m_we = 0; m_tout = '0;
    end else begin
      m_fq   = frame_clk;
      m_lq   = launch;
      m_we   = (m_mode == 2);
      m_tout = (m_mode == 2) ? crater_of(terrain_data, m_x / 16) : terrain_data;
      case (m_mode)
        0: if (ledge) begin
          a    = (int'(angle) > 9) ? 9 : int'(angle);
          m_x  = int'(launchX);
          m_y  = int'(launchY);
          m_vx = (bx_tab[a] * (int'(power) + 1)) >>> 1;
          m_vy = (by_tab[a] * (int'(power) + 1)) >>> 1;
          m_g  = 0;
          m_mode = 1;
        end
        1: if (tick) begin
          if (m_y + 2 + col_h(terrain_data, m_x / 16) >= 479) m_mode = 2;
          else begin
            nx = m_x + m_vx;
            ny = m_y + m_vy;
            if (nx < 0 || nx > 634 || ny > 474) m_mode = 0;
            else begin
              m_x = nx;
              m_y = (ny < 0) ? 0 : ny;
              m_g++;
              if (m_g == 6) begin m_g = 0; m_vy++; end
              if (m_vy > 10)  m_vy = 10;
              if (m_vy < -10) m_vy = -10;
            end
          end
        end
        2: begin m_mode = 3; m_b = 0; end
        default: if (tick) begin
          m_b++;
          if (m_b == 16) m_mode = 0;
        end
      endcase
    end
  end

  // Compare DUT against the model on every falling edge.
  always @(negedge clk) begin
    int ms;
    ms = (m_mode == 0) ? 0 : (m_mode == 3) ? 2 + m_b : 2;
    check("outputs", {X, Y, S, exploded, busy, terrain_we},
          {10'(m_x), 10'(m_y), 10'(ms), m_mode == 3, m_mode != 0, m_we});
    check("terrain_out", terrain_out, m_tout);
  end

  // Terrain write pulses, sampled on the pre-edge value.
  int           we_count = 0;
  logic [511:0] we_cap = '0;
  always @(posedge clk) begin
    if (terrain_we === 1'b1) begin
      we_count++;
      we_cap = terrain_out;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_tick();
    frame_clk = 1'b1;
    @(negedge clk);
    frame_clk = 1'b0;
    @(negedge clk);
  endtask

  task automatic set_flat(input int h);
    for (int c = 0; c < 64; c++) terrain_data[8*c +: 8] = 8'(h);
  endtask

  task automatic shoot(input int x, input int y, input int a, input int p);
    launchX = 10'(x); launchY = 10'(y); angle = 4'(a); power = 3'(p);
    launch = 1'b1;
    @(negedge clk);
    launch = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int n, wc;
    reset = 1'b1; frame_clk = 1'b0; launch = 1'b0;
    launchX = '0; launchY = '0; angle = '0; power = '0; terrain_data = '0;
    cyc(2);
    check("reset_state", {X, Y, S, exploded, busy, terrain_we, terrain_out}, '0);
    reset = 1'b0;
    cyc(2);

    // Flat terrain, shallow left shot.
    set_flat(0);
    shoot(320, 200, 4, 1);
    check("t2_launch", {busy, X, Y, S}, {1'b1, 10'd320, 10'd200, 10'd2});
    do_tick();
    check("t2_tick1", {X, Y}, {10'd319, 10'd196});
    repeat (5) do_tick();
    check("t2_tick6", {X, Y}, {10'd314, 10'd176});
    do_tick();
    check("t2_tick7_vy", {X, Y}, {10'd313, 10'd173});

    // Reset while flying.
    wc = we_count;
    reset = 1'b1;
    @(negedge clk);
    check("t1_reset", {S, busy, exploded}, '0);
    reset = 1'b0;
    cyc(3);
    check("t1_no_we", 32'(we_count), 32'(wc));
    check("t1_idle", {29'd0, busy}, '0);

    // Immediate off-screen dud.
    wc = we_count;
    shoot(630, 100, 9, 7);
    check("t3_busy", {31'd0, busy}, 1);
    do_tick();
    cyc(2);
    check("t3_dud", {31'd0, busy}, 0);
    check("t3_no_we", 32'(we_count), 32'(wc));

    // Vertical drop into a raised column 20.
    set_flat(50);
    terrain_data[8*20 +: 8] = 8'd100;
    wc = we_count;
    shoot(325, 300, 5, 0);
    n = 0;
    while (!exploded && busy && n < 300) begin do_tick(); n++; end
    check("t4_exploded", {31'd0, exploded}, 1);
    check("t4_hit_y", {31'd0, (Y >= 10'd377) && (Y <= 10'd386)}, 1);
    cyc(1);
    check("t4_we_once", 32'(we_count), 32'(wc + 1));
    check("t4_crater", {we_cap[8*22 +: 8], we_cap[8*21 +: 8], we_cap[8*20 +: 8], we_cap[8*19 +: 8]},
          {8'd50, 8'd44, 8'd88, 8'd44});
    n = 0;
    while (exploded && n < 100) begin do_tick(); n++; end
    check("t4_blast_ticks", 32'(n), 32'd16);
    check("t4_idle", {31'd0, busy}, 0);

    // Saturation at a shallow column 0.
    set_flat(30);
    terrain_data[7:0] = 8'd5;
    shoot(8, 472, 5, 0);
    do_tick();
    cyc(1);
    check("t5_crater", {we_cap[8*63 +: 8], we_cap[8*2 +: 8], we_cap[8*1 +: 8], we_cap[7:0]},
          {8'd30, 8'd30, 8'd24, 8'd0});
    n = 0;
    while (busy && n < 40) begin do_tick(); n++; end
    check("t5_idle", {31'd0, busy}, 0);

    // Held launch, tick coinciding with the launch edge, then a re-pulse mid-flight.
    set_flat(0);
    launchX = 10'd320; launchY = 10'd200; angle = 4'd4; power = 3'd1;
    launch = 1'b1;
    repeat (30) do_tick();
    launch = 1'b0;
    repeat (2) do_tick();
    launchX = 10'd100;
    launch = 1'b1;
    do_tick();
    launch = 1'b0;
    do_tick();
    check("t6_one_shot", {busy, X, Y}, {1'b1, 10'd287, 10'd143});
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      frame_clk = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) launch = ~launch;
      launchX = 10'($urandom_range(0, 634));
      launchY = 10'($urandom_range(0, 474));
      angle   = 4'($urandom_range(0, 15));
      power   = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 199) == 0) begin
        for (int c = 0; c < 64; c++) terrain_data[8*c +: 8] = 8'($urandom_range(0, 150));
      end
      reset = ($urandom_range(0, 2999) == 0);
    end
    reset = 1'b0;
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
